// File: rtl/pcs_receive.sv
// 8b/10b PCS receive path: registers the synchronizer output, decodes code groups,
// and tracks idle / frame delineation to produce GMII-style RXD/RX_DV/RX_ER.
module pcs_receive (
    input  logic        clk,
    input  logic        RESET,
    input  logic        code_status,
    input  logic [9:0]  rx_code_group,
    output logic [7:0]  RXD,
    output logic        RX_DV,
    output logic        RX_ER,
    output logic        receiving,
    output logic [15:0] frame_len,
    output logic        frame_done
);

    localparam int unsigned CG_W  = 10;
    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] S_WAIT_FOR_K = 3'd0;
    localparam logic [2:0] S_RX_K       = 3'd1;
    localparam logic [2:0] S_IDLE_D     = 3'd2;
    localparam logic [2:0] S_RECEIVE    = 3'd3;
    localparam logic [2:0] S_TRI_RRI    = 3'd4;

    localparam logic [2:0] K_INVALID = 3'd0;
    localparam logic [2:0] K_DATA    = 3'd1;
    localparam logic [2:0] K_COMMA   = 3'd2;
    localparam logic [2:0] K_SOP     = 3'd3;
    localparam logic [2:0] K_EOP     = 3'd4;
    localparam logic [2:0] K_CARRY   = 3'd5;

    localparam logic [CG_W-1:0] CG_D5_6  = 10'b1010010110;
    localparam logic [CG_W-1:0] CG_D16_2 = 10'b1001000101;

    logic              cs_q;
    logic [CG_W-1:0]   cg_q;
    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CNT_W-1:0]  cnt_inc;
    logic [2:0]        dec_kind;
    logic [7:0]        dec_val;
    logic [7:0]        rxd_nx;
    logic              dv_nx;
    logic              er_nx;
    logic              rcv_nx;
    logic [CNT_W-1:0]  flen_nx;
    logic              done_nx;

    // Single input stage; everything downstream works on the registered copy.
    always_ff @(posedge clk) begin
        if (RESET) begin
            cs_q <= 1'b0;
            cg_q <= '0;
        end else begin
            cs_q <= code_status;
            cg_q <= rx_code_group;
        end
    end

    // Code-group decode, both running disparities accepted.
    always_comb begin
        dec_kind = K_INVALID;
        dec_val  = 8'h00;
        case (cg_q)
            10'b1001110100, 10'b0110001011: begin dec_kind = K_DATA; dec_val = 8'h00; end
            10'b0111010100, 10'b1000101011: begin dec_kind = K_DATA; dec_val = 8'h01; end
            10'b1011010100, 10'b0100101011: begin dec_kind = K_DATA; dec_val = 8'h02; end
            10'b1100011011, 10'b1100010100: begin dec_kind = K_DATA; dec_val = 8'h03; end
            10'b1101010100, 10'b0010101011: begin dec_kind = K_DATA; dec_val = 8'h04; end
            10'b1010011011, 10'b1010010100: begin dec_kind = K_DATA; dec_val = 8'h05; end
            10'b0110011011, 10'b0110010100: begin dec_kind = K_DATA; dec_val = 8'h06; end
            10'b1110001011, 10'b0001110100: begin dec_kind = K_DATA; dec_val = 8'h07; end
            10'b1110010100, 10'b0001101011: begin dec_kind = K_DATA; dec_val = 8'h08; end
            10'b1001011011, 10'b1001010100: begin dec_kind = K_DATA; dec_val = 8'h09; end
            CG_D5_6:                        begin dec_kind = K_DATA; dec_val = 8'hC5; end
            CG_D16_2:                       begin dec_kind = K_DATA; dec_val = 8'h50; end
            10'b0011111010, 10'b1100000101: dec_kind = K_COMMA;
            10'b1101101000, 10'b0010010111: dec_kind = K_SOP;
            10'b1011101000, 10'b0100010111: dec_kind = K_EOP;
            10'b1110101000, 10'b0001010111: dec_kind = K_CARRY;
            default:                        dec_kind = K_INVALID;
        endcase
    end

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rxd_nx   = 8'h00;
        dv_nx    = 1'b0;
        er_nx    = 1'b0;
        flen_nx  = frame_len;
        done_nx  = 1'b0;
        if (!cs_q) begin
            state_nx = S_WAIT_FOR_K;
            er_nx    = (state == S_RECEIVE);
        end else begin
            case (state)
                S_WAIT_FOR_K: begin
                    if (dec_kind == K_COMMA) state_nx = S_RX_K;
                end
                S_RX_K: begin
                    if (cg_q == CG_D5_6 || cg_q == CG_D16_2) state_nx = S_IDLE_D;
                    else                                     state_nx = S_WAIT_FOR_K;
                end
                S_IDLE_D: begin
                    if (dec_kind == K_COMMA) begin
                        state_nx = S_RX_K;
                    end else if (dec_kind == K_SOP) begin
                        state_nx = S_RECEIVE;
                        rxd_nx   = 8'h55;
                        dv_nx    = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        // False carrier: anything else where idle data was expected.
                        state_nx = S_WAIT_FOR_K;
                        rxd_nx   = 8'h0E;
                        er_nx    = 1'b1;
                    end
                end
                S_RECEIVE: begin
                    if (dec_kind == K_DATA) begin
                        rxd_nx = dec_val;
                        dv_nx  = 1'b1;
                        cnt_nx = cnt_inc;
                    end else if (dec_kind == K_EOP) begin
                        state_nx = S_TRI_RRI;
                        flen_nx  = cnt;
                        done_nx  = 1'b1;
                    end else if (dec_kind == K_COMMA) begin
                        state_nx = S_RX_K;
                        er_nx    = 1'b1;
                    end else begin
                        rxd_nx = 8'hFF;
                        dv_nx  = 1'b1;
                        er_nx  = 1'b1;
                        cnt_nx = cnt_inc;
                    end
                end
                S_TRI_RRI: begin
                    if (dec_kind == K_CARRY)      state_nx = S_TRI_RRI;
                    else if (dec_kind == K_COMMA) state_nx = S_RX_K;
                    else                          state_nx = S_WAIT_FOR_K;
                end
                default: state_nx = S_WAIT_FOR_K;
            endcase
        end
        rcv_nx = (state_nx == S_RECEIVE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= S_WAIT_FOR_K;
            cnt        <= '0;
            RXD        <= 8'h00;
            RX_DV      <= 1'b0;
            RX_ER      <= 1'b0;
            receiving  <= 1'b0;
            frame_len  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            RXD        <= rxd_nx;
            RX_DV      <= dv_nx;
            RX_ER      <= er_nx;
            receiving  <= rcv_nx;
            frame_len  <= flen_nx;
            frame_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_pcs_receive.sv
// Self-checking bench for pcs_receive: directed scenarios plus random traffic,
// compared every cycle against a behavioural receive model.
module tb_pcs_receive;

    logic        clk;
    logic        RESET;
    logic        code_status;
    logic [9:0]  rx_code_group;
    logic [7:0]  RXD;
    logic        RX_DV;
    logic        RX_ER;
    logic        receiving;
    logic [15:0] frame_len;
    logic        frame_done;

    pcs_receive dut (
        .clk           (clk),
        .RESET         (RESET),
        .code_status   (code_status),
        .rx_code_group (rx_code_group),
        .RXD           (RXD),
        .RX_DV         (RX_DV),
        .RX_ER         (RX_ER),
        .receiving     (receiving),
        .frame_len     (frame_len),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] D56  = 10'b1010010110;
    localparam logic [9:0] D162 = 10'b1001000101;
    localparam logic [9:0] SS   = 10'b1101101000;
    localparam logic [9:0] TT   = 10'b1011101000;
    localparam logic [9:0] RR   = 10'b1110101000;
    localparam logic [9:0] D00  = 10'b1001110100;
    localparam logic [9:0] D10  = 10'b0111010100;
    localparam logic [9:0] D20  = 10'b1011010100;
    localparam logic [9:0] D30  = 10'b1100011011;

    localparam int C_INV = 0, C_DATA = 1, C_K285 = 2, C_S = 3, C_T = 4, C_R = 5;

    typedef enum int {M_WAIT, M_RXK, M_IDLE, M_RECV, M_TRI} mstate_t;

    logic [9:0] code_q [$];
    int         kind_q [$];
    logic [7:0] val_q  [$];

    mstate_t    m_st;
    int         m_cnt;
    int         m_flen;
    logic [7:0] e_rxd;
    logic       e_dv, e_er, e_rcv, e_done;
    logic       prev_cs;
    logic [9:0] prev_cg;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int done_seen = 0;
    int cyc = 0;

    task automatic addc(input logic [9:0] c, input int k, input logic [7:0] v);
        code_q.push_back(c);
        kind_q.push_back(k);
        val_q.push_back(v);
    endtask

    function automatic void classify(input logic [9:0] cg, output int k, output logic [7:0] v);
        k = C_INV;
        v = 8'h00;
        foreach (code_q[i]) if (code_q[i] == cg) begin k = kind_q[i]; v = val_q[i]; end
    endfunction

    // Behavioural receive rules applied to the group the DUT is currently acting on.
    task automatic model(input logic rst, input logic cs, input logic [9:0] cg);
        int k;
        logic [7:0] v;
        e_rxd = 8'h00; e_dv = 1'b0; e_er = 1'b0; e_done = 1'b0;
        if (rst) begin
            m_st = M_WAIT; m_cnt = 0; m_flen = 0; e_rcv = 1'b0;
            return;
        end
        classify(cg, k, v);
        if (!cs) begin
            e_er = (m_st == M_RECV);
            m_st = M_WAIT;
        end else begin
            case (m_st)
                M_WAIT: if (k == C_K285) m_st = M_RXK;
                M_RXK:  m_st = (k == C_DATA && (v == 8'hC5 || v == 8'h50)) ? M_IDLE : M_WAIT;
                M_IDLE: begin
                    if (k == C_K285) m_st = M_RXK;
                    else if (k == C_S) begin
                        m_st = M_RECV; e_rxd = 8'h55; e_dv = 1'b1; m_cnt = 0;
                    end else begin
                        m_st = M_WAIT; e_rxd = 8'h0E; e_er = 1'b1;
                    end
                end
                M_RECV: begin
                    if (k == C_DATA) begin
                        e_rxd = v; e_dv = 1'b1; m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    end else if (k == C_T) begin
                        m_st = M_TRI; m_flen = m_cnt; e_done = 1'b1;
                    end else if (k == C_K285) begin
                        m_st = M_RXK; e_er = 1'b1;
                    end else begin
                        e_rxd = 8'hFF; e_dv = 1'b1; e_er = 1'b1;
                        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    end
                end
                default: begin
                    if (k == C_R) m_st = M_TRI;
                    else if (k == C_K285) m_st = M_RXK;
                    else m_st = M_WAIT;
                end
            endcase
        end
        e_rcv = (m_st == M_RECV);
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic cs, input logic [9:0] cg);
        RESET = rst; code_status = cs; rx_code_group = cg;
        @(posedge clk);
        #1;
        cyc++;
        model(rst, prev_cs, prev_cg);
        if (rst) begin prev_cs = 1'b0; prev_cg = 10'd0; end
        else     begin prev_cs = cs;   prev_cg = cg;    end
        chk("rxd",        {8'h00, RXD},         {8'h00, e_rxd});
        chk("rx_dv",      {15'h0, RX_DV},       {15'h0, e_dv});
        chk("rx_er",      {15'h0, RX_ER},       {15'h0, e_er});
        chk("receiving",  {15'h0, receiving},   {15'h0, e_rcv});
        chk("frame_len",  frame_len,            16'(m_flen));
        chk("frame_done", {15'h0, frame_done},  {15'h0, e_done});
        if (frame_done === 1'b1) done_seen++;
    endtask

    task automatic send(input logic [9:0] cg);
        step(1'b0, 1'b1, cg);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) begin send(K285); send(D162); end
    endtask

    function automatic logic [9:0] rand_data();
        int idx;
        idx = int'($urandom_range(21, 0));
        return code_q[idx];
    endfunction

    initial begin
        int d0;
        int n;
        RESET = 1'b1; code_status = 1'b0; rx_code_group = 10'd0;
        prev_cs = 1'b0; prev_cg = 10'd0;
        m_st = M_WAIT; m_cnt = 0; m_flen = 0;

        addc(10'b1001110100, C_DATA, 8'h00); addc(10'b0110001011, C_DATA, 8'h00);
        addc(10'b0111010100, C_DATA, 8'h01); addc(10'b1000101011, C_DATA, 8'h01);
        addc(10'b1011010100, C_DATA, 8'h02); addc(10'b0100101011, C_DATA, 8'h02);
        addc(10'b1100011011, C_DATA, 8'h03); addc(10'b1100010100, C_DATA, 8'h03);
        addc(10'b1101010100, C_DATA, 8'h04); addc(10'b0010101011, C_DATA, 8'h04);
        addc(10'b1010011011, C_DATA, 8'h05); addc(10'b1010010100, C_DATA, 8'h05);
        addc(10'b0110011011, C_DATA, 8'h06); addc(10'b0110010100, C_DATA, 8'h06);
        addc(10'b1110001011, C_DATA, 8'h07); addc(10'b0001110100, C_DATA, 8'h07);
        addc(10'b1110010100, C_DATA, 8'h08); addc(10'b0001101011, C_DATA, 8'h08);
        addc(10'b1001011011, C_DATA, 8'h09); addc(10'b1001010100, C_DATA, 8'h09);
        addc(D56, C_DATA, 8'hC5);            addc(D162, C_DATA, 8'h50);
        addc(K285, C_K285, 8'h00);           addc(10'b1100000101, C_K285, 8'h00);
        addc(SS, C_S, 8'h00);                addc(10'b0010010111, C_S, 8'h00);
        addc(TT, C_T, 8'h00);                addc(10'b0100010111, C_T, 8'h00);
        addc(RR, C_R, 8'h00);                addc(10'b0001010111, C_R, 8'h00);

        step(1'b1, 1'b0, 10'd0);
        step(1'b1, 1'b1, 10'd0);

        // Basic frame of three data octets.
        d0 = done_seen;
        send(K285); send(D56); send(K285); send(D56); send(K285); send(D56);
        send(SS); send(D10); send(D20); send(D30); send(TT); send(RR); send(K285);
        send(D162);
        chk("basic_frame_len", frame_len, 16'h0003);
        chk("basic_done_pulses", 16'(done_seen - d0), 16'd1);

        // False carrier from idle.
        idles(2);
        send(D00); send(K285);
        chk("false_carrier_er", {15'h0, RX_ER}, 16'h0001);
        chk("false_carrier_rxd", {8'h00, RXD}, 16'h000E);
        send(D162);

        // Invalid code mid-frame counts as an errored octet.
        idles(1);
        send(SS); send(D10); send(10'b1111111111); send(D20); send(TT); send(RR);
        chk("invalid_mid_frame_len", frame_len, 16'h0003);

        // Loss of sync mid-frame, commas ignored until sync returns.
        idles(1);
        d0 = done_seen;
        send(SS); send(D10);
        step(1'b0, 1'b0, D20);
        step(1'b0, 1'b0, K285);
        step(1'b0, 1'b0, K285);
        step(1'b0, 1'b1, TT);
        send(K285); send(D162);
        chk("sync_loss_no_done", 16'(done_seen - d0), 16'd0);

        // Early end on comma, then a fresh frame.
        idles(1);
        send(SS); send(D10); send(D20); send(K285); send(D162);
        send(SS); send(D30); send(TT); send(RR); send(K285);
        chk("restart_frame_len", frame_len, 16'h0001);
        send(D162);

        // Reset in the middle of a frame.
        d0 = done_seen;
        idles(1);
        send(SS); send(D10); send(D20);
        step(1'b1, 1'b1, D30);
        send(TT); send(K285);
        chk("reset_no_done", 16'(done_seen - d0), 16'd0);
        chk("reset_frame_len", frame_len, 16'h0000);

        // Random traffic: idles, frames with occasional junk, sync drops.
        for (int f = 0; f < 150; f++) begin
            idles(int'($urandom_range(3, 0)));
            if ($urandom_range(9, 0) == 0) send(10'($urandom));
            send(SS);
            n = int'($urandom_range(12, 0));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(19, 0))
                    0:       send(10'($urandom));
                    1:       step(1'b0, 1'b0, rand_data());
                    2:       send(RR);
                    default: send(rand_data());
                endcase
            end
            case ($urandom_range(3, 0))
                0:       send(K285);
                1:       send(10'($urandom));
                default: begin send(TT); send(RR); end
            endcase
        end

        // Oversized frame saturates the length.
        idles(2);
        send(SS);
        for (int i = 0; i < 70000; i++) send(rand_data());
        send(TT); send(RR);
        chk("saturated_frame_len", frame_len, 16'hFFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pcs_receive.md
PCS_RECEIVE -- requirements
Module: pcs_receive

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 code_status  input  1  1 = upstream synchronizer holds sync; 0 = loss of sync.
REQ-005 rx_code_group  input  10  aligned code group from synchronizer, one per clk.
REQ-006 RXD  output  8  decoded octet.
REQ-007 RX_DV  output  1  RXD carries frame data.
REQ-008 RX_ER  output  1  receive error / false carrier indication.
REQ-009 receiving  output  1  high from /S/ through /T/ or abort.
REQ-010 frame_len  output  16  data-octet count of last completed frame.
REQ-011 frame_done  output  1  one-cycle pulse when frame_len updates.

Function
REQ-012 code_status and rx_code_group SHALL be registered once; FSM and decode act on the registered copy; all outputs SHALL be registered (code group at edge n affects outputs after edge n+2).
REQ-013 Decode table (either disparity), anything else SHALL be INVALID: D0.0 1001110100/0110001011->00; D1.0 0111010100/1000101011->01; D2.0 1011010100/0100101011->02; D3.0 1100011011/1100010100->03; D4.0 1101010100/0010101011->04; D5.0 1010011011/1010010100->05; D6.0 0110011011/0110010100->06; D7.0 1110001011/0001110100->07; D8.0 1110010100/0001101011->08; D9.0 1001011011/1001010100->09; D5.6 1010010110->C5; D16.2 1001000101->50; K28.5 0011111010/1100000101; K27.7 /S/ 1101101000/0010010111; K29.7 /T/ 1011101000/0100010111; K23.7 /R/ 1110101000/0001010111.
REQ-014 States: WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, TRI_RRI.
REQ-015 Registered code_status=0 SHALL force WAIT_FOR_K next, overriding all transitions; if in RECEIVE, emit RX_ER=1 for that one cycle and no frame_done.
REQ-016 WAIT_FOR_K: K28.5 -> RX_K; else stay; RX_DV=0, RX_ER=0.
REQ-017 RX_K: D5.6 or D16.2 -> IDLE_D; else -> WAIT_FOR_K.
REQ-018 IDLE_D: K28.5 -> RX_K; /S/ -> RECEIVE with RXD=55, RX_DV=1, receiving=1, byte counter=0; any other -> WAIT_FOR_K with RX_ER=1, RXD=0E (false carrier) one cycle.
REQ-019 RECEIVE data D0.0-D9.0/D5.6/D16.2: RXD=decoded, RX_DV=1, counter+1, stay.
REQ-020 RECEIVE /T/: -> TRI_RRI, RX_DV=0, receiving=0, frame_len<=counter, frame_done=1.
REQ-021 RECEIVE K28.5 (early end): -> RX_K, RX_DV=0, RX_ER=1 one cycle, receiving=0, no frame_done.
REQ-022 RECEIVE INVALID, /S/ or /R/: stay, RX_DV=1, RX_ER=1, RXD=FF, counter+1.
REQ-023 TRI_RRI: /R/ -> stay; K28.5 -> RX_K; other -> WAIT_FOR_K; no error flagged.
REQ-024 Counter SHALL saturate at FFFF, not wrap.
REQ-025 Outside RECEIVE and REQ-018, RXD SHALL be 00 and RX_DV=0.

Reset
REQ-026 RESET=1 at an edge SHALL set state WAIT_FOR_K, input registers to 0, RXD=00, RX_DV=0, RX_ER=0, receiving=0, frame_len=0000, frame_done=0, counter=0; mid-frame reset SHALL discard frame without frame_done.

Verification
REQ-027 code_status=1; K28.5,D5.6 x3, /S/, D1.0, D2.0, D3.0, /T/, /R/, K28.5 -> RXD 55,01,02,03 with RX_DV=1; frame_len=0003, frame_done one pulse.
REQ-028 In IDLE_D, D0.0 received -> RX_ER=1, RXD=0E one cycle, state WAIT_FOR_K.
REQ-029 Mid-frame 1111111111 -> RX_ER=1, RXD=FF, RX_DV=1; frame continues; frame_len counts it.
REQ-030 Mid-frame code_status drops -> RX_ER=1 one cycle, RX_DV=0 after, no frame_done, K28.5 ignored until code_status=1.
REQ-031 Mid-frame K28.5 -> RX_ER=1 one cycle, then D16.2 returns to IDLE_D; next /S/ starts fresh count.
REQ-032 RESET asserted during RECEIVE -> all outputs at REQ-026 values next edge; 70000-octet frame -> frame_len=FFFF.
